sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Shares the single byte-wide SDRAM controller port between three requesters:
- 0 = flash ROM loader (writes)
- 1 = NES CPU bus (reads, or writes to PRG-RAM)
- 2 = NES PPU bus (CHR reads)

Until load_done rises, only the loader is granted. After that, CPU and PPU share the port round-robin. Read data is routed back to the requester that issued the read, with a timeout guard. The block sits between the loader, the console core and the SDRAM controller.

Parameters:
ADDR_W, 23, SDRAM byte-address width
DATA_W, 8, data width
TIMEOUT, 255, maximum cycles to wait for sdram_out_valid after a read issue (8-bit counter; must be ≥1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load_done  in  1  ROM loader finished; level, expected to stay high
req_valid  in  3  per-requester request strobe, bit i = requester i
req_rw  in  3  per-requester direction, 1 = write, 0 = read
req_addr  in  3*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W]
req_wdata  in  3*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
req_busy  out  3  holding slot i is full; new requests on i are not accepted
rsp_valid  out  3  one-cycle read-data strobe to requester i
rsp_data  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid
rsp_err  out  1  sticky flag: a read timed out
sdram_addr  out  ADDR_W  to controller addr
sdram_rw  out  1  to controller rw, 1 = write
sdram_din  out  DATA_W  to controller data_in
sdram_in_valid  out  1  one-cycle command strobe
sdram_dout  in  DATA_W  controller data_out
sdram_busy  in  1  controller busy
sdram_out_valid  in  1  controller read-data strobe

Behaviour:
Reset values: all outputs 0; all slots empty; state IDLE; round-robin pointer set so the CPU wins first.

Holding slots:
- Each requester has one holding slot (addr, rw, wdata).
- req_busy[i] is the registered slot-full flag.
- When req_valid[i]=1 and the slot is empty at an edge, the slot captures the request.
- req_valid[i] while req_busy[i]=1 is ignored and the request is dropped; this is a requester protocol violation.

FSM, 3 states:
- IDLE:
  - load_done=0: only slot 0 is eligible.
  - load_done=1: slot 0 has fixed top priority; slots 1 and 2 alternate round-robin. The pointer toggles to the other requester after each grant to 1 or 2.
  - Grant on any eligible full slot: latch owner and slot contents into the sdram_* registers, go to ISSUE.
- ISSUE:
  - While sdram_busy=1: hold.
  - When sdram_busy=0: sdram_in_valid is high for exactly the next cycle, and the owner's slot clears at the same edge.
  - Write: go to IDLE.
  - Read: clear the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - sdram_out_valid=1: rsp_data <= sdram_dout, rsp_valid[owner]=1 for one cycle, go to IDLE.
  - Counter reaches TIMEOUT: rsp_data <= 8'hFF, rsp_valid[owner] pulses, rsp_err <= 1, go to IDLE.

Latency and throughput:
- From the edge that accepts a request (E0) with the controller idle: grant at E1, sdram_in_valid high from E2 to E3, req_busy low after E2.
- Back-to-back writes from one requester: one command per 3 cycles minimum.

Boundary cases:
- sdram_out_valid outside RD_WAIT is ignored.
- sdram_addr, sdram_rw and sdram_din are stable from grant until leaving ISSUE.
- A requester may hold a new request in its slot while its own read is in RD_WAIT.
- load_done falling after it was high re-blocks requesters 1 and 2; slots already captured are held, not dropped.
- Async reset mid-operation abandons any in-flight command or read; a late sdram_out_valid after reset is discarded.
- rsp_err clears only on reset.

Decomposition:
Shared package holds:
- state encodings IDLE/ISSUE/RD_WAIT
- requester index constants REQ_LOADER=0, REQ_CPU=1, REQ_PPU=2
- RW_WRITE=1, RW_READ=0

Sub-module: arb_req_slot, the per-requester holding register with its full flag, instantiated 3 times. The FSM and round-robin logic stay in the top level.

Test Plan:
- Loader phase: load_done=0; loader writes addr 0x008000 data 0xA5 while the CPU requests a read of 0x000010. Expect exactly one in_valid with rw=1, addr 0x008000, din 0xA5. The CPU slot stays held (req_busy[1]=1) and the CPU is not granted until load_done=1.
- Read routing: load_done=1; PPU reads 0x001234; model returns 0x3C 4 cycles after in_valid. Expect rsp_valid=3'b100 for one cycle with rsp_data=0x3C; rsp_valid[0] and rsp_valid[1] stay 0.
- Round-robin: CPU and PPU reads pending together, 4 times each. Grants alternate CPU, PPU, CPU, PPU…; each gets 4 responses. A loader request injected mid-sequence wins the next IDLE.
- Busy stall: hold sdram_busy=1 for 10 cycles during ISSUE. No in_valid pulse and addr stable throughout; exactly one in_valid on the cycle after busy falls.
- Timeout: TIMEOUT=16; CPU read, model never responds. Expect rsp_valid[1] with rsp_data=0xFF and rsp_err=1 after 16 cycles; a subsequent PPU read completes normally.
- Reset: assert rst during RD_WAIT, then deliver sdram_out_valid after release. Outputs go 0 immediately, no rsp_valid is produced, and req_busy=0.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM states, requester ids, direction codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sdram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] REQ_LOADER = 2'd0;
   localparam logic [1:0] REQ_CPU    = 2'd1;
   localparam logic [1:0] REQ_PPU    = 2'd2;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/sdram_port_arbiter_slot.sv
// Per-requester holding register: captures one request while empty and releases it on clear.
// Latency: full rises on the edge that captures the request.
// Backpressure: full stays high until the arbiter issues the command; requests arriving while full are dropped.
module arb_req_slot #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              clear,
   output logic              full,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata
);

   // Capture into an empty slot; clear and capture never coincide because clear implies full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full  <= 1'b0;
         rw    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (req_valid && !full) begin
         full  <= 1'b1;
         rw    <= req_rw;
         addr  <= req_addr;
         wdata <= req_wdata;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between loader, CPU and PPU; routes read data back to the issuer.
// Latency: accept at E0, grant at E1, sdram_in_valid high E2..E3; read data returns one cycle after sdram_out_valid.
// Backpressure: req_busy per requester while its slot is full; ISSUE holds while sdram_busy is high.
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_done,
   input  logic [2:0]          req_valid,
   input  logic [2:0]          req_rw,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wdata,
   output logic [2:0]          req_busy,
   output logic [2:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   sdram_addr,
   output logic                sdram_rw,
   output logic [DATA_W-1:0]   sdram_din,
   output logic                sdram_in_valid,
   input  logic [DATA_W-1:0]   sdram_dout,
   input  logic                sdram_busy,
   input  logic                sdram_out_valid
);

   // Last RD_WAIT count value before giving up; RD_WAIT lasts exactly TIMEOUT cycles without a response.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [2:0]        slot_full;
   logic [2:0]        slot_clear;
   logic [2:0]        slot_rw;
   logic [ADDR_W-1:0] slot_addr  [3];
   logic [DATA_W-1:0] slot_wdata [3];

   state_t            state, state_nxt;
   logic [1:0]        owner, grant_idx;
   logic [2:0]        owner_oh;
   logic              grant, issue, rd_done, rd_tmo;
   logic              rr_ppu;       // 1: PPU wins the next CPU/PPU tie
   logic [7:0]        tmo_cnt;
   logic              gnt_rw;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_wdata;

   genvar i;
   generate
      for (i = 0; i < 3; i++) begin : g_slot
         arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[i]),
            .req_rw    (req_rw[i]),
            .req_addr  (req_addr[i*ADDR_W +: ADDR_W]),
            .req_wdata (req_wdata[i*DATA_W +: DATA_W]),
            .clear     (slot_clear[i]),
            .full      (slot_full[i]),
            .rw        (slot_rw[i]),
            .addr      (slot_addr[i]),
            .wdata     (slot_wdata[i])
         );
         assign owner_oh[i]   = (owner == 2'(i));
         assign slot_clear[i] = issue && owner_oh[i];
      end
   endgenerate

   assign req_busy = slot_full;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, grant selection (loader first, then CPU/PPU round-robin) and completion events.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_idx = REQ_LOADER;
      gnt_rw    = slot_rw[REQ_LOADER];
      gnt_addr  = slot_addr[REQ_LOADER];
      gnt_wdata = slot_wdata[REQ_LOADER];
      issue     = 1'b0;
      rd_done   = 1'b0;
      rd_tmo    = 1'b0;
      case (state)
         IDLE: begin
            if (slot_full[REQ_LOADER]) begin
               grant = 1'b1;
            end else if (load_done && slot_full[REQ_CPU] && !(slot_full[REQ_PPU] && rr_ppu)) begin
               grant     = 1'b1;
               grant_idx = REQ_CPU;
               gnt_rw    = slot_rw[REQ_CPU];
               gnt_addr  = slot_addr[REQ_CPU];
               gnt_wdata = slot_wdata[REQ_CPU];
            end else if (load_done && slot_full[REQ_PPU]) begin
               grant     = 1'b1;
               grant_idx = REQ_PPU;
               gnt_rw    = slot_rw[REQ_PPU];
               gnt_addr  = slot_addr[REQ_PPU];
               gnt_wdata = slot_wdata[REQ_PPU];
            end
            if (grant) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (!sdram_busy) begin
               issue     = 1'b1;
               state_nxt = (sdram_rw == RW_WRITE) ? IDLE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (sdram_out_valid) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               rd_tmo    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command registers, round-robin pointer, timeout counter and response routing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner          <= REQ_LOADER;
         rr_ppu         <= 1'b0;
         tmo_cnt        <= '0;
         sdram_addr     <= '0;
         sdram_rw       <= RW_READ;
         sdram_din      <= '0;
         sdram_in_valid <= 1'b0;
         rsp_valid      <= '0;
         rsp_data       <= '0;
         rsp_err        <= 1'b0;
      end else begin
         sdram_in_valid <= issue;
         rsp_valid      <= '0;
         if (grant) begin
            owner      <= grant_idx;
            sdram_addr <= gnt_addr;
            sdram_rw   <= gnt_rw;
            sdram_din  <= gnt_wdata;
            if (grant_idx != REQ_LOADER) rr_ppu <= (grant_idx == REQ_CPU);
         end
         if (issue)                tmo_cnt <= '0;
         else if (state == RD_WAIT) tmo_cnt <= tmo_cnt + 8'd1;
         if (rd_done) begin
            rsp_data  <= sdram_dout;
            rsp_valid <= owner_oh;
         end else if (rd_tmo) begin
            rsp_data  <= '1;
            rsp_valid <= owner_oh;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
   } cmd_t;

   typedef struct packed {
      logic [2:0]        vec;
      logic [DATA_W-1:0] data;
      logic              err;
   } rsp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                load_done;
   logic [2:0]          req_valid, req_rw;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*DATA_W-1:0] req_wdata;
   logic [2:0]          req_busy, rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_err;
   logic [ADDR_W-1:0]   sdram_addr;
   logic                sdram_rw;
   logic [DATA_W-1:0]   sdram_din;
   logic                sdram_in_valid;
   logic [DATA_W-1:0]   sdram_dout;
   logic                sdram_busy;
   logic                sdram_out_valid;

   cmd_t exp_cmd[$];
   rsp_t exp_rsp[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_cmd = 0;
   int   rsp_cnt [3] = '{0, 0, 0};
   int   cyc = 0;
   int   cmd_cyc = 0;
   int   rsp_cyc = 0;
   logic exp_err = 1'b0;
   logic model_silent = 1'b0;
   int   model_delay = 4;

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .load_done(load_done),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_busy(req_busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .sdram_addr(sdram_addr), .sdram_rw(sdram_rw), .sdram_din(sdram_din),
      .sdram_in_valid(sdram_in_valid), .sdram_dout(sdram_dout), .sdram_busy(sdram_busy),
      .sdram_out_valid(sdram_out_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] mdata(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h08;
   endfunction

   // SDRAM controller model: answers reads model_delay cycles after the command strobe.
   initial begin
      sdram_out_valid = 1'b0;
      sdram_dout      = '0;
      forever begin
         logic [DATA_W-1:0] d;
         @(negedge clk);
         if (sdram_in_valid === 1'b1 && sdram_rw === 1'b0 && !model_silent) begin
            d = mdata(sdram_addr);
            repeat (model_delay - 1) @(negedge clk);
            sdram_dout      = d;
            sdram_out_valid = 1'b1;
            @(negedge clk);
            sdram_out_valid = 1'b0;
            sdram_dout      = '0;
         end
      end
   end

   // Command scoreboard.
   initial forever begin
      cmd_t e;
      @(negedge clk);
      if (sdram_in_valid === 1'b1) begin
         n_cmd++;
         cmd_cyc = cyc;
         vectors++;
         if (exp_cmd.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_unexpected: got rw=%b addr=%h din=%h, expected no command", sdram_rw, sdram_addr, sdram_din);
         end else begin
            e = exp_cmd.pop_front();
            if (sdram_rw !== e.rw || sdram_addr !== e.addr || (e.rw && sdram_din !== e.din)) begin
               miscompares++;
               $display("FAIL cmd: got rw=%b addr=%h din=%h, expected rw=%b addr=%h din=%h",
                        sdram_rw, sdram_addr, sdram_din, e.rw, e.addr, e.din);
            end
         end
      end
   end

   // Response scoreboard.
   initial forever begin
      rsp_t e;
      @(negedge clk);
      if (rsp_valid !== 3'b000) begin
         rsp_cyc = cyc;
         for (int i = 0; i < 3; i++) if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
         vectors++;
         if (exp_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: got vec=%b data=%h, expected no response", rsp_valid, rsp_data);
         end else begin
            e = exp_rsp.pop_front();
            if (rsp_valid !== e.vec || rsp_data !== e.data || rsp_err !== e.err) begin
               miscompares++;
               $display("FAIL rsp: got vec=%b data=%h err=%b, expected vec=%b data=%h err=%b",
                        rsp_valid, rsp_data, rsp_err, e.vec, e.data, e.err);
            end
         end
      end
   end

   task automatic exp_c(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_t c;
      c.rw = rw; c.addr = a; c.din = d;
      exp_cmd.push_back(c);
   endtask

   task automatic exp_r(input logic [2:0] vec, input logic [DATA_W-1:0] d, input logic err);
      rsp_t r;
      r.vec = vec; r.data = d; r.err = err;
      exp_rsp.push_back(r);
   endtask

   task automatic set_req(input int idx, input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[idx] = 1'b1;
      req_rw[idx]    = rw;
      req_addr[idx*ADDR_W +: ADDR_W]  = a;
      req_wdata[idx*DATA_W +: DATA_W] = d;
   endtask

   task automatic pulse_req();
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || req_busy !== 3'b000) && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL %s_drain: %0d cmds and %0d rsps outstanding, busy=%b after %0d cycles, expected all done",
                  name, exp_cmd.size(), exp_rsp.size(), req_busy, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; load_done = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0; sdram_busy = 1'b0;
      #1;
      vectors++;
      if ({sdram_in_valid, sdram_rw, sdram_addr, sdram_din, rsp_valid, rsp_data, rsp_err, req_busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got in_valid=%b addr=%h rsp_valid=%b err=%b busy=%b, expected all 0",
                  sdram_in_valid, sdram_addr, rsp_valid, rsp_err, req_busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loader_phase();
      int c0 = n_cmd;
      load_done = 1'b0;
      exp_c(1'b1, 23'h008000, 8'hA5);
      set_req(0, 1'b1, 23'h008000, 8'hA5);
      set_req(1, 1'b0, 23'h000010, 8'h00);
      pulse_req();
      vectors++;
      if (req_busy !== 3'b011) begin miscompares++; $display("FAIL loader_accept: busy=%b, expected 011", req_busy); end
      @(negedge clk);
      vectors++;
      if (sdram_in_valid !== 1'b0 || sdram_addr !== 23'h008000 || sdram_rw !== 1'b1) begin
         miscompares++;
         $display("FAIL loader_grant: in_valid=%b addr=%h rw=%b, expected 0 008000 1", sdram_in_valid, sdram_addr, sdram_rw);
      end
      @(negedge clk);
      vectors++;
      if (sdram_in_valid !== 1'b1 || req_busy !== 3'b010) begin
         miscompares++;
         $display("FAIL loader_issue: in_valid=%b busy=%b, expected 1 010", sdram_in_valid, req_busy);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (n_cmd - c0 != 1 || req_busy !== 3'b010) begin
         miscompares++;
         $display("FAIL loader_blocks_cpu: cmds=%0d busy=%b, expected 1 010", n_cmd - c0, req_busy);
      end
      exp_c(1'b0, 23'h000010, 8'h00);
      exp_r(3'b010, mdata(23'h000010), exp_err);
      load_done = 1'b1;
      wait_drain("loader", 50);
      vectors++;
      if (n_cmd - c0 != 2) begin miscompares++; $display("FAIL loader_total: cmds=%0d, expected 2", n_cmd - c0); end
   endtask

   task automatic test_read_routing();
      exp_c(1'b0, 23'h001234, 8'h00);
      exp_r(3'b100, 8'h3C, exp_err);
      set_req(2, 1'b0, 23'h001234, 8'h00);
      pulse_req();
      wait_drain("routing", 50);
      vectors++;
      if (rsp_cyc - cmd_cyc != 4) begin
         miscompares++;
         $display("FAIL routing_latency: %0d cycles from in_valid to rsp, expected 4", rsp_cyc - cmd_cyc);
      end
   endtask

   task automatic test_round_robin();
      int c1 = rsp_cnt[1];
      int c2 = rsp_cnt[2];
      for (int r = 0; r < 4; r++) begin
         logic [ADDR_W-1:0] a1, a2, al;
         a1 = 23'h000100 + 23'(r);
         a2 = 23'h000200 + 23'(r);
         al = 23'h009000 + 23'(r);
         exp_c(1'b0, a1, 8'h00);
         if (r == 1) exp_c(1'b1, al, 8'hC0);
         exp_c(1'b0, a2, 8'h00);
         exp_r(3'b010, mdata(a1), exp_err);
         exp_r(3'b100, mdata(a2), exp_err);
         set_req(1, 1'b0, a1, 8'h00);
         set_req(2, 1'b0, a2, 8'h00);
         pulse_req();
         if (r == 1) begin
            repeat (2) @(negedge clk);
            set_req(0, 1'b1, al, 8'hC0);
            pulse_req();
         end
         wait_drain("rr", 80);
      end
      vectors++;
      if (rsp_cnt[1] - c1 != 4 || rsp_cnt[2] - c2 != 4) begin
         miscompares++;
         $display("FAIL rr_counts: cpu=%0d ppu=%0d, expected 4 4", rsp_cnt[1] - c1, rsp_cnt[2] - c2);
      end
   endtask

   task automatic test_busy_stall();
      int bad = 0;
      sdram_busy = 1'b1;
      exp_c(1'b1, 23'h00ABCD, 8'h77);
      set_req(1, 1'b1, 23'h00ABCD, 8'h77);
      pulse_req();
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (sdram_in_valid !== 1'b0 || sdram_addr !== 23'h00ABCD || sdram_rw !== 1'b1 || sdram_din !== 8'h77) bad++;
         @(negedge clk);
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL stall_hold: %0d bad cycles, expected 0", bad); end
      sdram_busy = 1'b0;
      @(negedge clk);
      vectors++;
      if (sdram_in_valid !== 1'b1) begin miscompares++; $display("FAIL stall_release: in_valid=%b, expected 1", sdram_in_valid); end
      @(negedge clk);
      vectors++;
      if (sdram_in_valid !== 1'b0) begin miscompares++; $display("FAIL stall_single: in_valid=%b, expected 0", sdram_in_valid); end
      wait_drain("stall", 20);
   endtask

   task automatic test_timeout();
      model_silent = 1'b1;
      exp_err = 1'b1;
      exp_c(1'b0, 23'h000020, 8'h00);
      exp_r(3'b010, 8'hFF, 1'b1);
      set_req(1, 1'b0, 23'h000020, 8'h00);
      pulse_req();
      wait_drain("timeout", 60);
      vectors++;
      if (rsp_cyc - cmd_cyc != TIMEOUT || rsp_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_len: %0d cycles err=%b, expected %0d 1", rsp_cyc - cmd_cyc, rsp_err, TIMEOUT);
      end
      model_silent = 1'b0;
      exp_c(1'b0, 23'h000055, 8'h00);
      exp_r(3'b100, mdata(23'h000055), 1'b1);
      set_req(2, 1'b0, 23'h000055, 8'h00);
      pulse_req();
      wait_drain("after_timeout", 50);
      vectors++;
      if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: err=%b, expected 1", rsp_err); end
   endtask

   task automatic test_reset_midread();
      int n0 = n_cmd;
      int k = 0;
      int tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2];
      model_delay = 10;
      exp_c(1'b0, 23'h000040, 8'h00);
      set_req(1, 1'b0, 23'h000040, 8'h00);
      set_req(2, 1'b0, 23'h000041, 8'h00);
      pulse_req();
      while (n_cmd == n0 && k < 20) begin @(negedge clk); k++; end
      vectors++;
      if (k >= 20) begin miscompares++; $display("FAIL rst_cmd_wait: no command in 20 cycles, expected one"); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({sdram_in_valid, sdram_addr, sdram_din, rsp_valid, rsp_data, rsp_err, req_busy} !== '0) begin
         miscompares++;
         $display("FAIL rst_async: addr=%h rsp_valid=%b err=%b busy=%b, expected all 0", sdram_addr, rsp_valid, rsp_err, req_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_err = 1'b0;
      repeat (15) @(negedge clk);
      vectors++;
      if (rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] != tot || req_busy !== 3'b000 || exp_cmd.size() != 0) begin
         miscompares++;
         $display("FAIL rst_discard: rsps=%0d busy=%b pending_cmds=%0d, expected %0d 000 0",
                  rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2], req_busy, exp_cmd.size(), tot);
      end
      model_delay = 4;
   endtask

   initial begin
      test_reset();
      test_loader_phase();
      test_read_routing();
      test_round_robin();
      test_busy_stall();
      test_timeout();
      test_reset_midread();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
